// File: rtl/vram_line_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vram_line_fetch: fetches 1bpp scanlines from VRAM into a double-buffered   |
// | line store and serialises the previous line one pixel per enable.          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module vram_line_fetch #(
  parameter logic [13:0] VRAM_BASE      = 14'h2400,
  parameter int          BYTES_PER_LINE = 32,
  parameter bit          LSB_FIRST      = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_line_start,
  input  logic [7:0]  i_line,
  output logic [13:0] o_addr2,
  output logic        o_read2,
  input  logic [7:0]  i_data2,
  input  logic        i_ready2,
  input  logic        i_pix_en,
  output logic        o_pix,
  output logic        o_fetch_done,
  output logic        o_underrun
);

  localparam logic [4:0] LAST_BYTE = 5'(BYTES_PER_LINE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [7:0]  line_q;
  logic [4:0]  byte_idx;
  logic        fetch_done;
  logic        bank_sel;
  logic        front_valid;
  logic        underrun;
  logic        pix;
  logic [7:0]  pix_cnt;
  logic [7:0]  line_mem [0:63];

  logic        read_req;
  logic        ack;
  logic        last_byte;
  logic [13:0] fetch_addr;
  logic [7:0]  front_byte;
  logic [2:0]  bit_sel;

  // An acknowledge coinciding with a line strobe belongs to the aborted fetch.
  assign ack        = (state == WAIT) && i_ready2 && !i_line_start;
  assign last_byte  = (byte_idx == LAST_BYTE);
  assign fetch_addr = VRAM_BASE + {1'b0, line_q, 5'b0} + {9'b0, byte_idx};
  assign front_byte = line_mem[{bank_sel, pix_cnt[7:3]}];
  assign bit_sel    = LSB_FIRST ? pix_cnt[2:0] : ~pix_cnt[2:0];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    read_req   = 1'b0;
    case (state)
      IDLE: state_next = IDLE;
      REQ: begin
        read_req   = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (i_ready2) begin
          state_next = last_byte ? IDLE : REQ;
        end
      end
      default: state_next = IDLE;
    endcase
    if (i_line_start) begin
      state_next = REQ;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      line_q      <= 8'd0;
      byte_idx    <= 5'd0;
      fetch_done  <= 1'b0;
      bank_sel    <= 1'b0;
      front_valid <= 1'b0;
      underrun    <= 1'b0;
      pix_cnt     <= 8'd0;
      pix         <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (i_line_start) begin
        line_q      <= i_line;
        byte_idx    <= 5'd0;
        fetch_done  <= 1'b0;
        bank_sel    <= ~bank_sel;
        front_valid <= fetch_done;
        underrun    <= ~fetch_done;
        pix_cnt     <= 8'd0;
      end else begin
        if (ack) begin
          if (last_byte) begin
            fetch_done <= 1'b1;
          end else begin
            byte_idx <= byte_idx + 5'd1;
          end
        end
        if (i_pix_en) begin
          pix     <= front_valid & front_byte[bit_sel];
          pix_cnt <= pix_cnt + 8'd1;
        end
      end
    end
  end

  // The back bank is the one the pixel side is not reading.
  always_ff @(posedge i_clk) begin
    if (ack && !i_rst) begin
      line_mem[{~bank_sel, byte_idx}] <= i_data2;
    end
  end

  assign o_read2      = read_req;
  assign o_addr2      = read_req ? fetch_addr : 14'd0;
  assign o_pix        = pix;
  assign o_fetch_done = fetch_done;
  assign o_underrun   = underrun;

endmodule
`default_nettype wire
